// File: rtl/alu_if_pkg.sv
// alu_if_pkg: shared state encoding, byte geometry and flag layout for the ALU UART front end
package alu_if_pkg;
    localparam int BYTE_WIDTH = 8;
    localparam int ZERO_BIT = 0;
    localparam int OVF_BIT = 1;
    localparam logic [2:0] ST_WAIT_A   = 3'd0;
    localparam logic [2:0] ST_WAIT_B   = 3'd1;
    localparam logic [2:0] ST_WAIT_OP  = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_SEND_RES = 3'd4;
    localparam logic [2:0] ST_WAIT_RES = 3'd5;
    localparam logic [2:0] ST_SEND_FLG = 3'd6;
    localparam logic [2:0] ST_WAIT_FLG = 3'd7;
    typedef enum logic [2:0] {
        WAIT_A   = ST_WAIT_A,
        WAIT_B   = ST_WAIT_B,
        WAIT_OP  = ST_WAIT_OP,
        EXEC     = ST_EXEC,
        SEND_RES = ST_SEND_RES,
        WAIT_RES = ST_WAIT_RES,
        SEND_FLG = ST_SEND_FLG,
        WAIT_FLG = ST_WAIT_FLG
    } state_t;
    function automatic logic [BYTE_WIDTH-1:0] pack_flags(input logic ovf, input logic zero);
        logic [BYTE_WIDTH-1:0] f;
        f = '0;
        f[OVF_BIT] = ovf;
        f[ZERO_BIT] = zero;
        return f;
    endfunction
endpackage

// File: rtl/alu_uart_if_if.sv
// alu_uart_if_if: UART byte stream and ALU operand/result bundle around the sequencer
interface alu_uart_if_if #(parameter int DATA_WIDTH = 8, parameter int OP_WIDTH = 6);
    import alu_if_pkg::*;
    logic [BYTE_WIDTH-1:0] rx_data;
    logic rx_done;
    logic tx_done;
    logic [DATA_WIDTH-1:0] alu_result;
    logic alu_zero;
    logic alu_overflow;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [OP_WIDTH-1:0] alu_op;
    logic [BYTE_WIDTH-1:0] tx_data;
    logic tx_start;
    logic busy;
    logic [BYTE_WIDTH-1:0] rx_dropped;
    modport master (
        input  rx_data, rx_done, tx_done, alu_result, alu_zero, alu_overflow,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, rx_dropped
    );
    modport slave (
        output rx_data, rx_done, tx_done, alu_result, alu_zero, alu_overflow,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, rx_dropped
    );
endinterface

// File: rtl/alu_uart_if.sv
// alu_uart_if: gathers A, B, opcode bytes from UART RX, drives the ALU, returns result and flags over UART TX
module alu_uart_if
    import alu_if_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH = 6
) (
    input logic clk,
    input logic reset,
    alu_uart_if_if.master bus
);
    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [OP_WIDTH-1:0] op_q;
    logic [BYTE_WIDTH-1:0] result_q, flags_q, tx_data_q, dropped_q;
    logic busy;
    assign busy = state_q inside {EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= WAIT_A;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:   state_d = bus.rx_done ? WAIT_B : WAIT_A;
            WAIT_B:   state_d = bus.rx_done ? WAIT_OP : WAIT_B;
            WAIT_OP:  state_d = bus.rx_done ? EXEC : WAIT_OP;
            EXEC:     state_d = SEND_RES;
            SEND_RES: state_d = WAIT_RES;
            WAIT_RES: state_d = bus.tx_done ? SEND_FLG : WAIT_RES;
            SEND_FLG: state_d = WAIT_FLG;
            WAIT_FLG: state_d = bus.tx_done ? WAIT_A : WAIT_FLG;
            default:  state_d = WAIT_A;
        endcase
    end
    // tx_data is loaded on the edge that enters a SEND state so it is valid with tx_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            result_q <= '0;
            flags_q <= '0;
            tx_data_q <= '0;
            dropped_q <= '0;
        end else begin
            if (state_q == WAIT_A && bus.rx_done) a_q <= bus.rx_data[DATA_WIDTH-1:0];
            if (state_q == WAIT_B && bus.rx_done) b_q <= bus.rx_data[DATA_WIDTH-1:0];
            if (state_q == WAIT_OP && bus.rx_done) op_q <= bus.rx_data[OP_WIDTH-1:0];
            if (state_q == EXEC) begin
                result_q <= BYTE_WIDTH'(bus.alu_result);
                flags_q <= pack_flags(bus.alu_overflow, bus.alu_zero);
                tx_data_q <= BYTE_WIDTH'(bus.alu_result);
            end
            if (state_q == WAIT_RES && bus.tx_done) tx_data_q <= flags_q;
            if (busy && bus.rx_done && dropped_q != '1) dropped_q <= dropped_q + 8'd1;
        end
    end
    assign bus.alu_a = a_q;
    assign bus.alu_b = b_q;
    assign bus.alu_op = op_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_start = state_q == SEND_RES || state_q == SEND_FLG;
    assign bus.busy = busy;
    assign bus.rx_dropped = dropped_q;
endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: scoreboard bench for the ALU UART sequencer with a small ALU model attached
module tb_alu_uart_if;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    logic [7:0] r;
    logic ovf;

    alu_uart_if_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();
    alu_uart_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // lab ALU: MIPS-style funct codes ADD/SUB/AND/OR with signed overflow
    always_comb begin
        r = 8'h00;
        ovf = 1'b0;
        case (bus.alu_op)
            6'h20: begin r = bus.alu_a + bus.alu_b; ovf = (bus.alu_a[7] == bus.alu_b[7]) && (r[7] != bus.alu_a[7]); end
            6'h22: begin r = bus.alu_a - bus.alu_b; ovf = (bus.alu_a[7] != bus.alu_b[7]) && (r[7] != bus.alu_a[7]); end
            6'h24: r = bus.alu_a & bus.alu_b;
            6'h25: r = bus.alu_a | bus.alu_b;
            default: r = 8'h00;
        endcase
    end
    assign bus.alu_result = r;
    assign bus.alu_zero = (r == 8'h00);
    assign bus.alu_overflow = ovf;

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected got=%h expected none", bus.tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (bus.tx_data !== exp_byte) begin
                    failures++;
                    $display("FAIL tx_byte got=%h expected=%h", bus.tx_data, exp_byte);
                end
            end
        end
    end

    task automatic rx(input logic [7:0] d);
        @(negedge clk);
        bus.rx_data = d;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    task automatic do_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] er, input logic [7:0] ef);
        exp_q.push_back(er);
        exp_q.push_back(ef);
        rx(a);
        rx(b);
        rx(op);
        checks++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL exec_state tx_start=%b busy=%b expected tx_start=0 busy=1", bus.tx_start, bus.busy);
        end
        checks++;
        if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_op !== op[5:0]) begin
            failures++;
            $display("FAIL operands got=%h/%h/%h expected=%h/%h/%h", bus.alu_a, bus.alu_b, bus.alu_op, a, b, op[5:0]);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1) begin
            failures++;
            $display("FAIL res_latency tx_start=%b expected=1", bus.tx_start);
        end
        ack();
        checks++;
        if (bus.tx_start !== 1'b1) begin
            failures++;
            $display("FAIL flg_latency tx_start=%b expected=1", bus.tx_start);
        end
        ack();
        checks++;
        if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL triple_done busy=%b pending=%0d expected busy=0 pending=0", bus.busy, exp_q.size());
        end
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_op !== 6'h00 || bus.tx_data !== 8'h00 ||
            bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.rx_dropped !== 8'h00) begin
            failures++;
            $display("FAIL %s got a=%h b=%h op=%h tx=%h st=%b busy=%b drop=%h expected all zero", nm,
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.tx_data, bus.tx_start, bus.busy, bus.rx_dropped);
        end
    endtask

    task automatic test_reset();
        bus.rx_data = 8'hA5;
        bus.rx_done = 1'b1;
        bus.tx_done = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_values");
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_release");
    endtask

    task automatic test_add();
        do_triple(8'h05, 8'h03, 8'h20, 8'h08, 8'h00);
    endtask

    task automatic test_sub();
        do_triple(8'h05, 8'h05, 8'h22, 8'h00, 8'h01);
    endtask

    task automatic test_overflow();
        do_triple(8'h7F, 8'h01, 8'h20, 8'h80, 8'h02);
    endtask

    task automatic test_upper_bits();
        do_triple(8'h10, 8'h01, 8'hE2, 8'h0F, 8'h00);
    endtask

    task automatic test_dropped();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        rx(8'h10);
        rx(8'h20);
        rx(8'h24);
        @(negedge clk);
        rx(8'hAA);
        rx(8'hBB);
        rx(8'hCC);
        checks++;
        if (bus.rx_dropped !== 8'd3 || bus.tx_data !== 8'h00) begin
            failures++;
            $display("FAIL drop_wait_res got drop=%0d tx=%h expected drop=3 tx=00", bus.rx_dropped, bus.tx_data);
        end
        ack();
        @(negedge clk);
        bus.rx_data = 8'hDD;
        bus.rx_done = 1'b1;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        checks++;
        if (bus.rx_dropped !== 8'd4 || bus.busy !== 1'b0 || bus.alu_a !== 8'h10) begin
            failures++;
            $display("FAIL drop_count got drop=%0d busy=%b a=%h expected drop=4 busy=0 a=10",
                     bus.rx_dropped, bus.busy, bus.alu_a);
        end
        do_triple(8'h02, 8'h03, 8'h20, 8'h05, 8'h00);
    endtask

    task automatic test_reset_mid();
        rx(8'h11);
        rx(8'h22);
        checks++;
        if (bus.alu_a !== 8'h11 || bus.alu_b !== 8'h22) begin
            failures++;
            $display("FAIL partial got a=%h b=%h expected a=11 b=22", bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset_mid");
        do_triple(8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00);
    endtask

    task automatic test_saturate();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h00);
        rx(8'h03);
        rx(8'h04);
        rx(8'h20);
        @(negedge clk);
        for (int i = 0; i < 300; i++) rx(8'(i));
        checks++;
        if (bus.rx_dropped !== 8'd255 || bus.busy !== 1'b1 || bus.tx_data !== 8'h07) begin
            failures++;
            $display("FAIL saturate got drop=%0d busy=%b tx=%h expected drop=255 busy=1 tx=07",
                     bus.rx_dropped, bus.busy, bus.tx_data);
        end
        ack();
        ack();
        checks++;
        if (bus.rx_dropped !== 8'd255 || bus.busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL saturate_hold got drop=%0d busy=%b pending=%0d expected drop=255 busy=0 pending=0",
                     bus.rx_dropped, bus.busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_triple(8'hF0, 8'h0F, 8'h24, 8'h00, 8'h01);
        do_triple(8'h80, 8'h01, 8'h22, 8'h7F, 8'h02);
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_upper_bits();
        test_dropped();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_uart_if.md
# alu_uart_if

Byte-sequencing front end for the ALU. It collects three received UART bytes (operand A, operand B, opcode) and drives them as registered ALU inputs. It then captures the ALU's combinational result and flags and returns them as two bytes through the UART transmitter. It sits between the UART RX/TX pair and the ALU in the lab top level.

## Interface
Parameters:
- DATA_WIDTH, 8, ALU operand/result width; legal range 1..8.
- OP_WIDTH, 6, ALU opcode width; legal range 1..8.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_done=1.
- rx_done  in  1  one-cycle pulse: rx_data holds a new byte.
- tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- alu_result  in  DATA_WIDTH  combinational ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- alu_a  out  DATA_WIDTH  registered operand A.
- alu_b  out  DATA_WIDTH  registered operand B.
- alu_op  out  OP_WIDTH  registered opcode.
- tx_data  out  8  byte to transmit; held stable until tx_done.
- tx_start  out  1  one-cycle request to start transmission.
- busy  out  1  high from EXEC through WAIT_FLG.
- rx_dropped  out  8  saturating count of bytes ignored while busy.

## Operation
FSM states and transitions:
- WAIT_A: on rx_done, alu_a <= rx_data[DATA_WIDTH-1:0]; go to WAIT_B.
- WAIT_B: on rx_done, alu_b <= rx_data[DATA_WIDTH-1:0]; go to WAIT_OP.
- WAIT_OP: on rx_done, alu_op <= rx_data[OP_WIDTH-1:0]; go to EXEC.
- EXEC: ALU inputs are stable here. Register result_q <= alu_result (zero-extended to 8 bits) and flags_q <= {6'b0, alu_overflow, alu_zero}; go to SEND_RES.
- SEND_RES: tx_data = result_q, tx_start = 1; go to WAIT_RES.
- WAIT_RES: on tx_done, go to SEND_FLG.
- SEND_FLG: tx_data = flags_q, tx_start = 1; go to WAIT_FLG.
- WAIT_FLG: on tx_done, go to WAIT_A.

Rules:
- Upper rx_data bits beyond DATA_WIDTH/OP_WIDTH are discarded.
- alu_a/alu_b/alu_op hold their values until overwritten by the next sequence.
- rx_done while busy: byte discarded; rx_dropped increments and saturates at 255. This includes a rx_done coincident with tx_done in WAIT_FLG.
- tx_done in any state other than WAIT_RES/WAIT_FLG is ignored.
- rx_dropped is never cleared except by reset.

## Timing
- Reset values: state WAIT_A, alu_a=0, alu_b=0, alu_op=0, tx_data=0, tx_start=0, busy=0, rx_dropped=0, result_q=0, flags_q=0.
- Reset mid-sequence aborts immediately. A partially received triple is discarded, and any pending transmission request is dropped.
- alu_a/alu_b/alu_op update on the edge that samples rx_done.
- Opcode rx_done at cycle N gives: EXEC at N+1, SEND_RES (tx_start=1) at N+2, WAIT_RES from N+3.
- tx_done at cycle M in WAIT_RES gives SEND_FLG (tx_start=1) at M+1.
- tx_done in WAIT_FLG at cycle M gives WAIT_A at M+1; the earliest accepted next A byte is at M+1.
- tx_start is Moore-decoded and high exactly one cycle per byte.
- tx_data is registered and changes only on entry to SEND_RES/SEND_FLG.
- busy is Moore-decoded from the state register.

## Structure
- Shared package alu_if_pkg holds:
  - state encoding localparams (3-bit, eight states);
  - BYTE_WIDTH = 8;
  - flag bit positions: ZERO_BIT = 0, OVF_BIT = 1.
- No sub-module. The ALU, UART RX and UART TX are instantiated beside this block in the parent top.

## Test plan
- Bytes 0x05, 0x03, 0x20 (ADD), with the ALU model attached -> tx bytes 0x08 then 0x00; tx_start at opcode rx_done + 2 cycles.
- Bytes 0x05, 0x05, 0x22 (SUB) -> tx 0x00 then 0x01.
- Bytes 0x7F, 0x01, 0x20 -> tx 0x80 then 0x02 (overflow set).
- Three rx_done pulses during WAIT_RES, plus one coincident with tx_done in WAIT_FLG -> rx_dropped=4; tx bytes unchanged; next triple processed normally.
- Send A=0x11, B=0x22, then assert reset; then send 0x0F, 0xF0, 0x25 (OR) -> outputs at reset values after reset; tx 0xFF then 0x00.
- 300 rx_done pulses while busy (tx_done withheld) -> rx_dropped saturates at 255 and stays there.
